// File: rtl/alloc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : alloc_dispatcher
// Function : Issues one allocation request at a time to the find table,
//            re-issuing blocked requests after a back-off period.
// Revision : 1.0 - initial release
// ============================================================================
module alloc_dispatcher #(
    parameter int ID_W      = 8,
    parameter int SIZE_W    = 2,
    parameter int ISSUE_GAP = 2,
    parameter int RETRY_GAP = 4,
    parameter int MAX_RETRY = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [ID_W-1:0]   req_id_in,
    input  logic [SIZE_W-1:0] req_size_in,
    output logic              alloc_valid_fdt_out,
    output logic [ID_W-1:0]   alloc_id_fdt_out,
    output logic [SIZE_W-1:0] alloc_size_fdt_out,
    input  logic              fdt_blocked_in,
    output logic              done_valid_out,
    output logic              done_fail_out,
    output logic [ID_W-1:0]   done_id_out,
    output logic              busy_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CHECK   = 3'd2,
        S_BACKOFF = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    localparam logic [3:0] c_issue_gap_m1 = 4'(ISSUE_GAP - 1);
    localparam logic [3:0] c_retry_gap_m1 = 4'(RETRY_GAP - 1);
    localparam logic [7:0] c_max_retry    = 8'(MAX_RETRY);

    state_t            r_state;
    logic [ID_W-1:0]   r_id;
    logic [SIZE_W-1:0] r_size;
    logic [7:0]        r_retry;
    logic [3:0]        r_gap;

    logic [7:0]        w_retry_inc;
    logic              w_exhausted;

    // Saturating increment keeps the count meaningful when retrying forever.
    assign w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
    assign w_exhausted = (MAX_RETRY != 0) && (w_retry_inc == c_max_retry);

    assign req_ready_out = (r_state == S_IDLE);
    assign busy_out      = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state             <= S_IDLE;
            r_id                <= '0;
            r_size              <= '0;
            r_retry             <= 8'd0;
            r_gap               <= 4'd0;
            alloc_valid_fdt_out <= 1'b0;
            alloc_id_fdt_out    <= '0;
            alloc_size_fdt_out  <= '0;
            done_valid_out      <= 1'b0;
            done_fail_out       <= 1'b0;
            done_id_out         <= '0;
        end else begin
            alloc_valid_fdt_out <= 1'b0;
            done_valid_out      <= 1'b0;
            done_fail_out       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid_in) begin
                        r_id                <= req_id_in;
                        r_size              <= req_size_in;
                        r_retry             <= 8'd0;
                        alloc_valid_fdt_out <= 1'b1;
                        alloc_id_fdt_out    <= req_id_in;
                        alloc_size_fdt_out  <= req_size_in;
                        r_state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!fdt_blocked_in) begin
                        done_valid_out <= 1'b1;
                        done_id_out    <= r_id;
                        if (ISSUE_GAP > 0) begin
                            r_gap   <= c_issue_gap_m1;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_retry <= w_retry_inc;
                        if (w_exhausted) begin
                            done_valid_out <= 1'b1;
                            done_fail_out  <= 1'b1;
                            done_id_out    <= r_id;
                            r_state        <= S_IDLE;
                        end else begin
                            r_gap   <= c_retry_gap_m1;
                            r_state <= S_BACKOFF;
                        end
                    end
                end
                S_BACKOFF: begin
                    // The issue pulse is launched on the last back-off cycle so it
                    // is visible during the ISSUE state.
                    if (r_gap == 4'd0) begin
                        alloc_valid_fdt_out <= 1'b1;
                        alloc_id_fdt_out    <= r_id;
                        alloc_size_fdt_out  <= r_size;
                        r_state             <= S_ISSUE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                S_GAP: begin
                    if (r_gap == 4'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alloc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_alloc_dispatcher
// Function : Directed vector table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alloc_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid_in = 1'b0;
    logic       req_ready_out;
    logic [7:0] req_id_in = 8'h00;
    logic [1:0] req_size_in = 2'd0;
    logic       alloc_valid_fdt_out;
    logic [7:0] alloc_id_fdt_out;
    logic [1:0] alloc_size_fdt_out;
    logic       fdt_blocked_in = 1'b0;
    logic       done_valid_out;
    logic       done_fail_out;
    logic [7:0] done_id_out;
    logic       busy_out;

    alloc_dispatcher #(
        .ID_W      (8),
        .SIZE_W    (2),
        .ISSUE_GAP (2),
        .RETRY_GAP (4),
        .MAX_RETRY (3)
    ) u_dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_in        (req_valid_in),
        .req_ready_out       (req_ready_out),
        .req_id_in           (req_id_in),
        .req_size_in         (req_size_in),
        .alloc_valid_fdt_out (alloc_valid_fdt_out),
        .alloc_id_fdt_out    (alloc_id_fdt_out),
        .alloc_size_fdt_out  (alloc_size_fdt_out),
        .fdt_blocked_in      (fdt_blocked_in),
        .done_valid_out      (done_valid_out),
        .done_fail_out       (done_fail_out),
        .done_id_out         (done_id_out),
        .busy_out            (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rn;
        logic       v;
        logic [7:0] id;
        logic [1:0] sz;
        logic       blk;
        logic       rdy;
        logic       av;
        logic [7:0] aid;
        logic [1:0] asz;
        logic       dv;
        logic       df;
        logic [7:0] did;
        logic       bsy;
    } vec_t;

    vec_t vecs [11];

    int n_vec = 0;
    int n_err = 0;

    logic       s_rdy, s_av, s_dv, s_df, s_bsy;
    logic [7:0] s_aid, s_did;
    logic [1:0] s_asz;

    logic [31:0] h_av, h_dv, h_df, h_rdy;

    // Outputs are sampled on the falling edge (state of the current cycle),
    // then the inputs for that same cycle are driven.
    task automatic cyc(input logic rn, input logic v, input logic [7:0] id,
                       input logic [1:0] sz, input logic blk);
        @(negedge clk);
        s_rdy = req_ready_out;
        s_av  = alloc_valid_fdt_out;
        s_aid = alloc_id_fdt_out;
        s_asz = alloc_size_fdt_out;
        s_dv  = done_valid_out;
        s_df  = done_fail_out;
        s_did = done_id_out;
        s_bsy = busy_out;
        rst_n          = rn;
        req_valid_in   = v;
        req_id_in      = id;
        req_size_in    = sz;
        fdt_blocked_in = blk;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_hist();
        h_av = '0; h_dv = '0; h_df = '0; h_rdy = '0;
    endtask

    task automatic rec(input int k);
        h_av[k]  = s_av;
        h_dv[k]  = s_dv;
        h_df[k]  = s_df;
        h_rdy[k] = s_rdy;
    endtask

    initial begin
        logic [7:0] ids [4];
        logic [7:0] got_aid [4];
        logic [7:0] got_did [4];
        int idx, na, nd;

        //            rn   v    id     sz    blk | rdy  av   aid    asz   dv   df   did    bsy
        vecs[0]  = '{1'b1,1'b1,8'h15,2'd2,1'b0, 1'b1,1'b0,8'h00,2'd0,1'b0,1'b0,8'h00,1'b0};
        vecs[1]  = '{1'b1,1'b1,8'h77,2'd3,1'b1, 1'b0,1'b1,8'h15,2'd2,1'b0,1'b0,8'h00,1'b1};
        vecs[2]  = '{1'b1,1'b0,8'h00,2'd0,1'b0, 1'b0,1'b0,8'h15,2'd2,1'b0,1'b0,8'h00,1'b1};
        vecs[3]  = '{1'b1,1'b1,8'h55,2'd0,1'b1, 1'b0,1'b0,8'h15,2'd2,1'b1,1'b0,8'h15,1'b1};
        vecs[4]  = '{1'b1,1'b0,8'h00,2'd0,1'b1, 1'b0,1'b0,8'h15,2'd2,1'b0,1'b0,8'h15,1'b1};
        vecs[5]  = '{1'b1,1'b1,8'h3A,2'd1,1'b0, 1'b1,1'b0,8'h15,2'd2,1'b0,1'b0,8'h15,1'b0};
        vecs[6]  = '{1'b1,1'b0,8'h00,2'd0,1'b1, 1'b0,1'b1,8'h3A,2'd1,1'b0,1'b0,8'h15,1'b1};
        vecs[7]  = '{1'b1,1'b0,8'h00,2'd0,1'b0, 1'b0,1'b0,8'h3A,2'd1,1'b0,1'b0,8'h15,1'b1};
        vecs[8]  = '{1'b1,1'b0,8'h00,2'd0,1'b1, 1'b0,1'b0,8'h3A,2'd1,1'b1,1'b0,8'h3A,1'b1};
        vecs[9]  = '{1'b1,1'b0,8'h00,2'd0,1'b0, 1'b0,1'b0,8'h3A,2'd1,1'b0,1'b0,8'h3A,1'b1};
        vecs[10] = '{1'b1,1'b0,8'h00,2'd0,1'b0, 1'b1,1'b0,8'h3A,2'd1,1'b0,1'b0,8'h3A,1'b0};

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 2'd0, 1'b0);

        // Table: reset state, single request, ignored requests while busy,
        // blocked flag wiggled outside CHECK.
        for (int i = 0; i < 11; i++) begin
            cyc(vecs[i].rn, vecs[i].v, vecs[i].id, vecs[i].sz, vecs[i].blk);
            chk($sformatf("vec%0d", i),
                32'({s_rdy, s_av, s_aid, s_asz, s_dv, s_df, s_did, s_bsy}),
                32'({vecs[i].rdy, vecs[i].av, vecs[i].aid, vecs[i].asz,
                     vecs[i].dv, vecs[i].df, vecs[i].did, vecs[i].bsy}));
        end

        // Four back-to-back requests, never blocked.
        ids[0] = 8'h11; ids[1] = 8'h22; ids[2] = 8'h33; ids[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin got_aid[i] = '0; got_did[i] = '0; end
        idx = 0; na = 0; nd = 0;
        clr_hist();
        for (int k = 0; k < 25; k++) begin
            cyc(1'b1, idx < 4, (idx < 4) ? ids[idx] : 8'h00, 2'd1, 1'b0);
            rec(k);
            if (s_av && na < 4) begin got_aid[na] = s_aid; na++; end
            if (s_dv && nd < 4) begin got_did[nd] = s_did; nd++; end
            if (s_rdy && req_valid_in) idx++;
        end
        chk("b2b_accepted", 32'(idx), 32'd4);
        chk("b2b_issue_times", h_av, 32'h0001_0842);
        chk("b2b_done_times", h_dv, 32'h0004_2108);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_issue_id%0d", i), 32'(got_aid[i]), 32'(ids[i]));
            chk($sformatf("b2b_done_id%0d", i), 32'(got_did[i]), 32'(ids[i]));
        end

        // Blocked in the first two CHECKs (t+2, t+8), clear at t+14.
        clr_hist();
        for (int k = 0; k < 19; k++) begin
            cyc(1'b1, k == 0, 8'hA1, 2'd3, k <= 8);
            rec(k);
            if (k == 13) chk("blk2_reissue_id", 32'({s_aid, s_asz}), 32'({8'hA1, 2'd3}));
            if (k == 15) chk("blk2_done_id", 32'(s_did), 32'h0000_00A1);
        end
        chk("blk2_ready_t0", 32'(h_rdy[0]), 32'd1);
        chk("blk2_issue_times", h_av, 32'h0000_2082);
        chk("blk2_done_times", h_dv, 32'h0000_8000);
        chk("blk2_fail_flags", h_df, 32'h0000_0000);

        // Held blocked with MAX_RETRY=3; next request taken in the fail cycle.
        clr_hist();
        for (int k = 0; k < 21; k++) begin
            cyc(1'b1, (k == 0) || (k == 15), (k == 15) ? 8'h5E : 8'hC3, 2'd0, k <= 14);
            rec(k);
            if (k == 15) chk("fail_done_id", 32'(s_did), 32'h0000_00C3);
            if (k == 16) chk("fail_next_issue_id", 32'(s_aid), 32'h0000_005E);
            if (k == 18) chk("fail_next_done_id", 32'(s_did), 32'h0000_005E);
        end
        chk("fail_issue_times", h_av, 32'h0001_2082);
        chk("fail_done_times", h_dv, 32'h0004_8000);
        chk("fail_fail_flags", h_df, 32'h0000_8000);
        chk("fail_ready_t15", 32'(h_rdy[15]), 32'd1);

        // Reset pulse during BACKOFF drops the request.
        clr_hist();
        for (int k = 0; k < 15; k++) begin
            cyc(k != 4, k == 0, 8'h9D, 2'd2, k == 2);
            rec(k);
            if (k == 5) chk("rst_busy", 32'(s_bsy), 32'd0);
        end
        chk("rst_issue_times", h_av, 32'h0000_0002);
        chk("rst_done_times", h_dv, 32'h0000_0000);
        chk("rst_ready_times", h_rdy, 32'h0000_7FE1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
